// File: rtl/ofdm_cp_remover.sv
// ofdm_cp_remover
//   Sits behind the Schmidl-Cox detector in the ce_clk domain. It strips the
//   cyclic prefix of every OFDM symbol and forwards exactly 2^fft_log2 samples
//   per symbol to the FFT, with tlast on the last sample of each symbol.
//   Samples outside a detected frame are dropped.
//
// Optional feature (macro OFDM_CP_REMOVE_TIMING_ADV_EN):
//   Adds cfg_timing_adv. Symbol 0 skips cp_len - adv samples (adv saturated
//   to cp_len), so every FFT window opens adv samples early inside the CP.
//   Without the macro the port is absent and adv behaves as 0.
//
// Ports:
//   ce_clk, ce_rst_n       clock, asynchronous active-low reset
//   cfg_fft_log2           log2 FFT size (clamped to 3..MAX_FFT_LOG2)
//   cfg_cp_len             CP length in samples
//   cfg_num_sym            symbols per frame (0 behaves as 1)
//   cfg_timing_adv         (macro only) early FFT window start
//   s_axis_*               detector sample stream, tuser marks frame start
//   m_axis_*               FFT-bound stream, tuser on first sample of frame
//   busy                   high whenever the FSM is not IDLE
//   frame_count            frames fully emitted, wraps
module ofdm_cp_remover #(
  parameter int ITEM_W       = 32,
  parameter int MAX_FFT_LOG2 = 12,
  parameter int SYM_W        = 8,
  parameter int CNT_W        = 16
) (
  input  logic                    ce_clk,
  input  logic                    ce_rst_n,
  input  logic [3:0]              cfg_fft_log2,
  input  logic [MAX_FFT_LOG2-1:0] cfg_cp_len,
  input  logic [SYM_W-1:0]        cfg_num_sym,
`ifdef OFDM_CP_REMOVE_TIMING_ADV_EN
  input  logic [MAX_FFT_LOG2-1:0] cfg_timing_adv,
`endif
  input  logic [ITEM_W-1:0]       s_axis_tdata,
  input  logic                    s_axis_tuser,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [ITEM_W-1:0]       m_axis_tdata,
  output logic                    m_axis_tuser,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    busy,
  output logic [CNT_W-1:0]        frame_count
);

  localparam int CW = MAX_FFT_LOG2 + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, CP = 2'd1, DATA = 2'd2} state_t;
  state_t state, state_next;

  logic [3:0]              log2_in, log2_q;
  logic [MAX_FFT_LOG2-1:0] skip0_in, skip0_q, cp_q, cp_skip;
  logic [SYM_W-1:0]        last_sym_in, last_sym_q, sym_cnt;
  logic [CW-1:0]           cnt, win_max;
  logic                    frame_end_q;
  logic                    in_xfer, out_xfer, out_blocked, start, load_out;
  logic                    cp_done, win_last, last_sym;

  // Effective configuration as seen at the frame-start sample. Sizes below 8
  // are clamped up too, so a window always spans several samples.
  always_comb begin
    log2_in = cfg_fft_log2;
    if (cfg_fft_log2 > 4'(MAX_FFT_LOG2))
      log2_in = 4'(MAX_FFT_LOG2);
    else if (cfg_fft_log2 < 4'd3)
      log2_in = 4'd3;
  end

`ifdef OFDM_CP_REMOVE_TIMING_ADV_EN
  // Symbol 0 skips cp_len - adv, with adv saturated to cp_len.
  always_comb begin
    if (cfg_timing_adv > cfg_cp_len)
      skip0_in = '0;
    else
      skip0_in = cfg_cp_len - cfg_timing_adv;
  end
`else
  assign skip0_in = cfg_cp_len;
`endif

  assign last_sym_in = (cfg_num_sym == '0) ? '0 : cfg_num_sym - SYM_W'(1);

  assign in_xfer     = s_axis_tvalid & s_axis_tready;
  assign out_xfer    = m_axis_tvalid & m_axis_tready;
  assign out_blocked = m_axis_tvalid & ~m_axis_tready;
  assign start       = (state == IDLE) & in_xfer & s_axis_tuser;

  assign win_max  = (CW'(1) << log2_q) - CW'(1);
  assign cp_skip  = (sym_cnt == '0) ? skip0_q : cp_q;
  assign cp_done  = (cnt == ({1'b0, cp_skip} - CW'(1)));
  assign win_last = (cnt == win_max);
  assign last_sym = (sym_cnt == last_sym_q);

  // A zero-skip frame start forwards its very first sample straight from IDLE.
  assign load_out = ((state == DATA) & in_xfer) | (start & (skip0_in == '0));

  // State register
  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Next state. A skip of 0 or 1 is fully consumed by the frame-start sample.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start)
          state_next = (skip0_in[MAX_FFT_LOG2-1:1] == '0) ? DATA : CP;
      end
      CP: begin
        if (in_xfer && cp_done)
          state_next = DATA;
      end
      DATA: begin
        if (in_xfer && win_last) begin
          if (last_sym)
            state_next = IDLE;
          else if (cp_q == '0)
            state_next = DATA;
          else
            state_next = CP;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs. In IDLE ready only drops when a zero-skip frame start
  // would have to overwrite an output sample the FFT has not taken yet.
  always_comb begin
    busy          = (state != IDLE);
    s_axis_tready = 1'b1;
    case (state)
      IDLE:    s_axis_tready = ~out_blocked | (skip0_in != '0);
      CP:      s_axis_tready = 1'b1;
      DATA:    s_axis_tready = ~out_blocked;
      default: s_axis_tready = 1'b1;
    endcase
  end

  // Config latch plus CP / window / symbol counters
  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      log2_q     <= '0;
      cp_q       <= '0;
      skip0_q    <= '0;
      last_sym_q <= '0;
      cnt        <= '0;
      sym_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            log2_q     <= log2_in;
            cp_q       <= cfg_cp_len;
            skip0_q    <= skip0_in;
            last_sym_q <= last_sym_in;
            sym_cnt    <= '0;
            cnt        <= (skip0_in == MAX_FFT_LOG2'(1)) ? '0 : CW'(1);
          end
        end
        CP: begin
          if (in_xfer)
            cnt <= cp_done ? '0 : cnt + CW'(1);
        end
        DATA: begin
          if (in_xfer) begin
            if (win_last) begin
              cnt <= '0;
              if (!last_sym)
                sym_cnt <= sym_cnt + SYM_W'(1);
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  // Single registered output stage. frame_end_q tags the frame's final sample
  // so the frame is counted only when the FFT actually takes it.
  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      m_axis_tdata  <= '0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tvalid <= 1'b0;
      frame_end_q   <= 1'b0;
    end else if (load_out) begin
      m_axis_tdata  <= s_axis_tdata;
      m_axis_tvalid <= 1'b1;
      m_axis_tuser  <= start | ((sym_cnt == '0) & (cnt == '0));
      m_axis_tlast  <= (state == DATA) & win_last;
      frame_end_q   <= (state == DATA) & win_last & last_sym;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
      frame_end_q   <= 1'b0;
    end
  end

  // Completed-frame counter
  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n)
      frame_count <= '0;
    else if (out_xfer && frame_end_q)
      frame_count <= frame_count + CNT_W'(1);
  end

endmodule
